fetch_ctrl: RTL
===============

Name: fetch_ctrl

Overview:
- Fetch-stage sequencer for the 5-stage MIPS pipeline.
- Owns the architectural PC register and issues one-at-a-time requests to the instruction memory over a req/gnt/rvalid handshake.
- Presents fetched instructions to the IF/ID register. Applies stall requests from the hazard unit and branch/jump redirects from the ID-stage next-PC logic, honouring the MIPS delay slot.

Parameters:
RESET_PC, 32'h0000_3000, first fetch address after reset
ADDR_W, 32, PC/address width (only 32 supported)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
stall_i  in  1  hazard unit: IF/ID must hold its current contents
redirect_i  in  1  ID stage: control transfer resolved this cycle
redirect_pc_i  in  32  target of the transfer (word aligned)
imem_req_o  out  1  fetch request
imem_addr_o  out  32  fetch address, stable while imem_req_o=1 and not granted
imem_gnt_i  in  1  memory accepted the request this cycle
imem_rvalid_i  in  1  response data valid (>=1 cycle after gnt)
imem_rdata_i  in  32  instruction word
if_valid_o  out  1  if_instr_o/if_pc_o hold a valid instruction
if_pc_o  out  32  PC of presented instruction
if_instr_o  out  32  presented instruction
pc_o  out  32  address of the next fetch (debug/trace)

Behaviour:
- Reset (reset=0, async):
  - State=BOOT; pc_q=RESET_PC; redir_pend=0.
  - imem_req_o=0, if_valid_o=0, if_pc_o=0, if_instr_o=0, pc_o=RESET_PC.
- States: BOOT, REQ, WAIT, HOLD.
  - BOOT: one cycle after reset release, then -> REQ.
  - REQ: imem_req_o=1, imem_addr_o=pc_q. On imem_gnt_i -> WAIT; else stay, address unchanged.
  - WAIT: imem_req_o=0. On imem_rvalid_i, capture if_pc_o=pc_q and if_instr_o=imem_rdata_i, set if_valid_o=1. pc_q <= redir_pend ? redir_tgt : pc_q+4, clear redir_pend.
    - stall_i=0 -> REQ (next fetch issued the cycle after capture).
    - stall_i=1 -> HOLD.
  - HOLD: outputs frozen, imem_req_o=0. -> REQ on the first cycle with stall_i=0.
- if_valid_o deasserts the cycle after the IF/ID consumer takes the instruction (stall_i=0 while in REQ/WAIT), so bubbles are visible as if_valid_o=0.
- Latency: zero-wait memory (gnt same cycle as req, rvalid next cycle) gives one instruction per 2 cycles; pipelined throughput is out of scope.
- Redirect / delay slot:
  - redirect_i samples redirect_pc_i into redir_tgt and sets redir_pend.
  - The instruction currently in flight or presented is the delay slot and is never discarded.
  - The fetch following it uses redir_tgt.
  - If redirect_i arrives in WAIT on the same cycle as rvalid, the capture applies the redirect immediately (pc_q <= redirect_pc_i).
- Redirect while stall_i=1: latched; no change to presented outputs; applied at the next capture.
- Second redirect while redir_pend=1: newer target overwrites the older one.
- stall_i during REQ: request still completes; stall only affects the transition out of WAIT.
- pc_q arithmetic: modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
- Low 2 bits of redirect_pc_i are forced to 0.
- Reset asserted mid-transaction: everything returns to reset values. A late rvalid arriving in BOOT is ignored.
- imem_rvalid_i outside WAIT: ignored.

Decomposition:
- Shared package mips_defs:
  - RESET_PC constant.
  - Fetch state encoding: BOOT=2'd0, REQ=2'd1, WAIT=2'd2, HOLD=2'd3.
- Sub-module fetch_redir_buf: redir_pend/redir_tgt register, with set/overwrite/consume logic.
- Remaining FSM, PC and output registers stay in fetch_ctrl.

Test Plan:
- Reset release, zero-wait memory returning 32'h2408_0001 @ 0x3000, 32'h2409_0002 @ 0x3004 -> first req at 0x3000 two cycles after release; if_pc_o 0x3000 then 0x3004; pc_o=0x3008.
- Gnt delayed 3 cycles -> imem_addr_o held at 0x3000 all 3 cycles; exactly one capture.
- Redirect to 0x3040 in WAIT of the 0x3004 fetch -> 0x3004 (delay slot) presented, next req at 0x3040, no fetch of 0x3008.
- stall_i=1 for 4 cycles after capture of 0x3000, plus redirect to 0x3100 during the stall -> outputs frozen, no req. After release, next fetch is 0x3004 (delay slot), then 0x3100.
- Redirect coincident with rvalid, target 0x3200 -> captured instruction kept; next req at 0x3200.
- Reset pulled low while in WAIT, rvalid one cycle after release -> response ignored; fetch restarts at 0x3000.

Source files
------------

// File: rtl/mips_defs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_defs (package)
// Brief    : Shared fetch-stage constants and state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package mips_defs;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_redir_buf.sv
`default_nettype none
// ============================================================================
// Module   : fetch_redir_buf
// Brief    : Pending control-transfer target; newest redirect wins, capture consumes.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_redir_buf #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_set,
    input  logic [ADDR_W-1:0] i_tgt,
    input  logic              i_consume,
    output logic              o_pend,
    output logic [ADDR_W-1:0] o_tgt
);

    logic              r_pend;
    logic [ADDR_W-1:0] r_tgt;
    logic [ADDR_W-1:0] w_tgt_aligned;

    assign w_tgt_aligned = i_tgt & ~ADDR_W'(3);

    // A redirect coinciding with the consuming capture is applied by that
    // capture directly, so consume takes priority over set here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= 1'b0;
            r_tgt  <= '0;
        end else if (i_consume) begin
            r_pend <= 1'b0;
        end else if (i_set) begin
            r_pend <= 1'b1;
            r_tgt  <= w_tgt_aligned;
        end
    end

    assign o_pend = i_set | r_pend;
    assign o_tgt  = i_set ? w_tgt_aligned : r_tgt;

endmodule
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl
// Brief    : MIPS fetch sequencer: PC register, one-at-a-time imem fetch, IF/ID output.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = mips_defs::RESET_PC,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_gnt_i,
    input  logic              imem_rvalid_i,
    input  logic [31:0]       imem_rdata_i,
    output logic              if_valid_o,
    output logic [ADDR_W-1:0] if_pc_o,
    output logic [31:0]       if_instr_o,
    output logic [ADDR_W-1:0] pc_o
);

    import mips_defs::*;

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] w_redir_tgt;
    logic              w_redir_pend;
    logic              w_capture;
    logic              w_consumed;
    logic              r_if_valid;
    logic [ADDR_W-1:0] r_if_pc;
    logic [31:0]       r_if_instr;

    fetch_redir_buf #(
        .ADDR_W (ADDR_W)
    ) u_redir_buf (
        .clk       (clk),
        .rst_n     (reset),
        .i_set     (redirect_i),
        .i_tgt     (redirect_pc_i),
        .i_consume (w_capture),
        .o_pend    (w_redir_pend),
        .o_tgt     (w_redir_tgt)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_consumed  = 1'b0;
        case (r_state)
            S_BOOT: w_state_nxt = S_REQ;
            S_REQ: begin
                if (imem_gnt_i) begin
                    w_state_nxt = S_WAIT;
                end
                w_consumed = !stall_i;
            end
            S_WAIT: begin
                if (imem_rvalid_i) begin
                    w_capture   = 1'b1;
                    w_state_nxt = stall_i ? S_HOLD : S_REQ;
                end else begin
                    w_consumed = !stall_i;
                end
            end
            S_HOLD: begin
                if (!stall_i) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: w_state_nxt = S_BOOT;
        endcase
        w_pc_nxt = w_redir_pend ? w_redir_tgt : r_pc + ADDR_W'(4);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The presented instruction is the delay slot: it is never dropped, only
    // replaced by the next capture or retired once the consumer takes it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc       <= RESET_PC;
            r_if_valid <= 1'b0;
            r_if_pc    <= '0;
            r_if_instr <= '0;
        end else if (w_capture) begin
            r_pc       <= w_pc_nxt;
            r_if_valid <= 1'b1;
            r_if_pc    <= r_pc;
            r_if_instr <= imem_rdata_i;
        end else if (w_consumed) begin
            r_if_valid <= 1'b0;
        end
    end

    assign imem_req_o  = (r_state == S_REQ);
    assign imem_addr_o = r_pc;
    assign pc_o        = r_pc;
    assign if_valid_o  = r_if_valid;
    assign if_pc_o     = r_if_pc;
    assign if_instr_o  = r_if_instr;

endmodule
`default_nettype wire
